// File: rtl/cond_exec_ctrl.sv
// ---------------------------------------------------------------------------
// cond_exec_ctrl
//
// Execute-stage condition controller. Holds the architectural NZCV flags,
// evaluates each instruction's condition field against them, gates register
// and memory writes of failed or wrong-path instructions, and runs a short
// flush sequencer after a taken branch to kill younger instructions.
//
// Ports:
//   clk           pipeline clock, rising edge
//   rst           asynchronous active-high reset
//   stall         pipeline freeze; holds all state, suppresses side effects
//   ex_valid      a real instruction occupies execute
//   ex_cond       condition field [31:28]
//   ex_setflags   S bit; write NZCV on pass
//   ex_is_branch  instruction is B/BL
//   ex_reg_write  decoder register-write request
//   ex_mem_write  decoder memory-write request
//   alu_nzcv      ALU result flags {N,Z,C,V}
//   nzcv_q        architectural flags {N,Z,C,V}
//   cond_pass     raw condition result (combinational)
//   reg_write_o   gated register write
//   mem_write_o   gated memory write
//   branch_taken  taken-branch pulse to PC select (combinational)
//   flush_if      kill IF/ID contents (registered)
//   flush_id      kill ID/EX contents (registered)
//   flush_busy    sequencer is in FLUSH
// ---------------------------------------------------------------------------
module cond_exec_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int NV_EXECUTES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       ex_valid,
    input  logic [3:0] ex_cond,
    input  logic       ex_setflags,
    input  logic       ex_is_branch,
    input  logic       ex_reg_write,
    input  logic       ex_mem_write,
    input  logic [3:0] alu_nzcv,
    output logic [3:0] nzcv_q,
    output logic       cond_pass,
    output logic       reg_write_o,
    output logic       mem_write_o,
    output logic       branch_taken,
    output logic       flush_if,
    output logic       flush_id,
    output logic       flush_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic       NV_PASS  = (NV_EXECUTES != 0);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       squash;
    logic       commit;

    // Condition table over {N,Z,C,V}.
    function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'd0:    eval_cond = z;
            4'd1:    eval_cond = !z;
            4'd2:    eval_cond = c;
            4'd3:    eval_cond = !c;
            4'd4:    eval_cond = n;
            4'd5:    eval_cond = !n;
            4'd6:    eval_cond = v;
            4'd7:    eval_cond = !v;
            4'd8:    eval_cond = c & !z;
            4'd9:    eval_cond = !c | z;
            4'd10:   eval_cond = (n == v);
            4'd11:   eval_cond = (n != v);
            4'd12:   eval_cond = !z & (n == v);
            4'd13:   eval_cond = z | (n != v);
            4'd14:   eval_cond = 1'b1;
            default: eval_cond = NV_PASS;
        endcase
    endfunction

    assign cond_pass    = eval_cond(ex_cond, nzcv_q);
    // Anything in execute while the flush runs is on the wrong path.
    assign squash       = (state_q == FLUSH);
    assign commit       = ex_valid & cond_pass & !squash & !stall;
    assign reg_write_o  = commit & ex_reg_write;
    assign mem_write_o  = commit & ex_mem_write;
    assign branch_taken = commit & ex_is_branch;

    assign flush_if   = (state_q == FLUSH);
    assign flush_id   = (state_q == FLUSH);
    assign flush_busy = (state_q == FLUSH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nzcv_q <= 4'b0000;
        end else if (commit && ex_setflags) begin
            nzcv_q <= alu_nzcv;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            case (state_q)
                IDLE: begin
                    if (branch_taken) begin
                        state_d = FLUSH;
                        cnt_d   = CNT_INIT;
                    end
                end
                FLUSH: begin
                    if (cnt_q == 3'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/cond_exec_ctrl.md
Name: cond_exec_ctrl

Overview:
- Execute-stage condition controller for the ARM pipeline.
- Owns the architectural NZCV flags register and evaluates each instruction's 4-bit condition code against it.
- Gates register and memory writes of failed or squashed instructions, and updates flags for S-suffixed instructions.
- On a taken branch, runs a flush sequencer that kills younger instructions in IF/ID for a fixed number of cycles.

Parameters:
- FLUSH_CYCLES, 2, number of consecutive cycles the flush sequencer holds the flush outputs after a taken branch (legal range 1..7).
- NV_EXECUTES, 1, condition code 15 outcome: 1 = always execute, 0 = never execute.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  pipeline freeze; holds all state, suppresses all side effects.
- ex_valid  input  1  a real instruction occupies the execute stage.
- ex_cond  input  4  instruction condition field [31:28].
- ex_setflags  input  1  S bit; instruction writes NZCV on pass.
- ex_is_branch  input  1  instruction is B/BL.
- ex_reg_write  input  1  decoder register-write request.
- ex_mem_write  input  1  decoder memory-write request.
- alu_nzcv  input  4  ALU result flags {N,Z,C,V} for the current instruction.
- nzcv_q  output  4  architectural flags {N,Z,C,V}.
- cond_pass  output  1  condition satisfied; combinational.
- reg_write_o  output  1  gated register write.
- mem_write_o  output  1  gated memory write.
- branch_taken  output  1  taken-branch pulse to PC select; combinational.
- flush_if  output  1  kill IF/ID register contents; registered.
- flush_id  output  1  kill ID/EX register contents; registered.
- flush_busy  output  1  sequencer is in FLUSH.

Behaviour:
- Reset (async, immediate):
  - nzcv_q=0000, state=IDLE, counter=0.
  - flush_if, flush_id and flush_busy are 0.
- Condition table, evaluated on nzcv_q (bits N=3, Z=2, C=1, V=0):
  - 0 EQ: Z. 1 NE: !Z.
  - 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z.
  - 10 GE: N==V. 11 LT: N!=V.
  - 12 GT: !Z&(N==V). 13 LE: Z|(N!=V).
  - 14 AL: 1. 15: NV_EXECUTES.
- squash = flush_busy. An instruction in execute during FLUSH is a wrong-path instruction.
- commit = ex_valid & cond_pass & !squash & !stall.
- Outputs:
  - cond_pass is the raw table result, independent of valid, stall or squash.
  - reg_write_o = commit & ex_reg_write.
  - mem_write_o = commit & ex_mem_write.
  - branch_taken = commit & ex_is_branch.
- Flags:
  - On a rising edge with commit & ex_setflags, nzcv_q <= alu_nzcv.
  - Otherwise nzcv_q holds.
  - No forwarding: an instruction sees flags written by an older instruction from the cycle after that write.
- Flush FSM, 2 states:
  - IDLE: when branch_taken, go to FLUSH and set counter=FLUSH_CYCLES-1.
  - FLUSH: each unstalled cycle, if counter==0 go to IDLE, else decrement counter.
  - stall=1 freezes state and counter in both states.
  - flush_if = flush_id = flush_busy = (state==FLUSH). All three are registered, so they assert the cycle after branch_taken.
- Latency: branch_taken in cycle T; flush outputs high for cycles T+1 .. T+FLUSH_CYCLES (not counting stalled cycles).
- Boundaries:
  - A branch in execute while in FLUSH is squashed: no re-trigger, no flag write.
  - ex_setflags on a taken branch updates flags and starts the flush in the same edge.
  - stall together with a passing branch: no branch_taken, no transition. The instruction is re-evaluated when stall drops.
  - ex_valid=0: all gated outputs are 0 and no state changes.
  - rst asserted mid-FLUSH: immediate return to IDLE with flush outputs 0; nzcv_q is cleared.

Test Plan:
- Reset then ex_valid=1, cond=0 (EQ), nzcv_q=0000 → cond_pass=0, reg_write_o=0. Then an AL instruction with setflags and alu_nzcv=0100 writes nzcv_q=0100; the next EQ gives cond_pass=1 and reg_write_o=1.
- Sweep all 16 codes over all 16 nzcv_q values → cond_pass matches the table, including LS with C=1,Z=1 → 1 and LE with Z=0,N=1,V=0 → 1.
- Taken AL branch at cycle T with FLUSH_CYCLES=2 → branch_taken=1 at T; flush_if/flush_id=1 at T+1 and T+2, 0 at T+3. A valid branch at T+1 gives branch_taken=0, and a setflags instruction at T+2 leaves nzcv_q unchanged.
- Taken branch followed by stall=1 for 3 cycles at T+1 → flush outputs stay 1 for those cycles; deassertion is delayed by 3 cycles.
- Failed MI branch (nzcv_q=0000) with ex_mem_write=1 → branch_taken=0, mem_write_o=0, and the FSM stays in IDLE.
- rst pulse while flush_busy=1 and nzcv_q=1010 → asynchronously flush_busy=0 and nzcv_q=0000, before the next clk edge.
